// File: rtl/button_conditioner.sv
// Per-channel pushbutton conditioner: two-flop synchronizer, counting debounce FSM,
// registered debounced level plus one-cycle press/release pulses.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned NUM_BUTTONS     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] btn_raw_n,
  output logic [NUM_BUTTONS-1:0] btn_n,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse
);

  localparam int unsigned CntW = 20;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StUpStable,
    StDownWait,
    StDownStable,
    StUpWait
  } state_e;

  // Async assert, synchronous release so every channel leaves reset on one edge.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    logic            s1_q;
    logic            s2_q;
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            btn_q;
    logic            press_q;
    logic            release_q;

    always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
        s1_q      <= 1'b1;
        s2_q      <= 1'b1;
        state_q   <= StUpStable;
        cnt_q     <= '0;
        btn_q     <= 1'b1;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        s1_q      <= btn_raw_n[g];
        s2_q      <= s1_q;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        unique case (state_q)
          StUpStable: begin
            if (!s2_q) begin
              state_q <= StDownWait;
              cnt_q   <= CntW'(1);
            end else begin
              cnt_q <= '0;
            end
          end
          StDownWait: begin
            if (s2_q) begin
              state_q <= StUpStable;
              cnt_q   <= '0;
            end else if (cnt_q == CntMax) begin
              state_q <= StDownStable;
              cnt_q   <= '0;
              btn_q   <= 1'b0;
              press_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StDownStable: begin
            if (s2_q) begin
              state_q <= StUpWait;
              cnt_q   <= CntW'(1);
            end else begin
              cnt_q <= '0;
            end
          end
          StUpWait: begin
            if (!s2_q) begin
              state_q <= StDownStable;
              cnt_q   <= '0;
            end else if (cnt_q == CntMax) begin
              state_q   <= StUpStable;
              cnt_q     <= '0;
              btn_q     <= 1'b1;
              release_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: begin
            state_q <= StUpStable;
            cnt_q   <= '0;
            btn_q   <= 1'b1;
          end
        endcase
      end
    end

    assign btn_n[g]         = btn_q;
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = release_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized plus directed bench for button_conditioner against a run-length model
// of the debounce rules.
module tb_button_conditioner;

  localparam int unsigned D  = 4;
  localparam int unsigned NB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_raw_n = '1;
  logic [NB-1:0] btn_n;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] release_pulse;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .NUM_BUTTONS    (NB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw_n    (btn_raw_n),
    .btn_n        (btn_n),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: raw delayed two cycles, then a level is accepted after D consecutive
  // observations that differ from the currently accepted level.
  logic [NB-1:0] m_p1 = '1, m_p2 = '1, m_acc = '1, m_press = '0, m_rel = '0;
  int            m_run[NB];
  int            m_rst_edges = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p1 = '1; m_p2 = '1; m_acc = '1; m_press = '0; m_rel = '0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
      m_rst_edges = 0;
    end else begin
      m_press = '0;
      m_rel   = '0;
      if (m_rst_edges < 2) begin
        m_p1 = '1; m_p2 = '1; m_acc = '1;
        for (int i = 0; i < NB; i++) m_run[i] = 0;
        m_rst_edges++;
      end else begin
        for (int i = 0; i < NB; i++) begin
          logic seen;
          seen     = m_p2[i];
          m_p2[i]  = m_p1[i];
          m_p1[i]  = btn_raw_n[i];
          if (seen != m_acc[i]) begin
            m_run[i]++;
            if (m_run[i] == int'(D)) begin
              m_acc[i] = seen;
              m_run[i] = 0;
              if (seen == 1'b0) m_press[i] = 1'b1;
              else m_rel[i] = 1'b1;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison plus pulse alternation tracking.
  logic [NB-1:0] expect_rel = '0;
  int            n_press[NB];
  int            n_rel[NB];

  initial for (int i = 0; i < NB; i++) begin n_press[i] = 0; n_rel[i] = 0; end

  always @(negedge clk) begin
    check("btn_n", 32'(btn_n), 32'(m_acc));
    check("press_pulse", 32'(press_pulse), 32'(m_press));
    check("release_pulse", 32'(release_pulse), 32'(m_rel));
    if (!rst_n) expect_rel = '0;
    for (int i = 0; i < NB; i++) begin
      if (press_pulse[i]) n_press[i]++;
      if (release_pulse[i]) n_rel[i]++;
      if (press_pulse[i] || release_pulse[i]) begin
        checks++;
        if ((press_pulse[i] && release_pulse[i]) || (press_pulse[i] && expect_rel[i]) ||
            (release_pulse[i] && !expect_rel[i])) begin
          errors++;
          $display("FAIL alternate ch%0d: press=%0b release=%0b, expected %s next", i,
                   press_pulse[i], release_pulse[i], expect_rel[i] ? "release" : "press");
        end
        expect_rel[i] = press_pulse[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic edge_sample();
    @(posedge clk);
    @(negedge clk);
  endtask

  int p0, p1, r0, r1;

  initial begin
    // Reset state, held with clock running
    ticks(3);
    #3;
    check("reset_btn_n", 32'(btn_n), 32'hf);
    check("reset_pulses", 32'({press_pulse, release_pulse}), 32'h0);
    tick();
    rst_n = 1'b1;
    ticks(6);

    // Single press on hl: falls on edge 5, pulse for exactly one cycle
    btn_raw_n[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      edge_sample();
      check($sformatf("press_btn0_e%0d", k), 32'(btn_n[0]), (k >= 5) ? 32'd0 : 32'd1);
      check($sformatf("press_pulse0_e%0d", k), 32'(press_pulse[0]), (k == 5) ? 32'd1 : 32'd0);
    end
    tick();
    btn_raw_n[0] = 1'b1;
    ticks(12);

    // Three-cycle glitch on hr is filtered
    btn_raw_n[1] = 1'b0;
    ticks(3);
    btn_raw_n[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("glitch_btn1", 32'(btn_n[1]), 32'd1);
      check("glitch_pulses1", 32'({press_pulse[1], release_pulse[1]}), 32'd0);
      tick();
    end

    // Bouncing release on vu
    btn_raw_n[2] = 1'b0;
    ticks(10);
    btn_raw_n[2] = 1'b1; tick();
    btn_raw_n[2] = 1'b0; tick();
    btn_raw_n[2] = 1'b1; tick();
    btn_raw_n[2] = 1'b0; tick();
    btn_raw_n[2] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      edge_sample();
      check($sformatf("bounce_btn2_e%0d", k), 32'(btn_n[2]), (k >= 5) ? 32'd1 : 32'd0);
      check($sformatf("bounce_rel2_e%0d", k), 32'(release_pulse[2]), (k == 5) ? 32'd1 : 32'd0);
    end
    tick();
    ticks(4);

    // All four pressed on the same edge
    btn_raw_n = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      edge_sample();
      check($sformatf("all_btn_e%0d", k), 32'(btn_n), (k >= 5) ? 32'h0 : 32'hf);
      check($sformatf("all_press_e%0d", k), 32'(press_pulse), (k == 5) ? 32'hf : 32'h0);
    end
    tick();
    btn_raw_n = 4'b1111;
    ticks(12);

    // Reset mid-wait on vd, button held through release
    btn_raw_n[3] = 1'b0;
    for (int k = 0; k < 4; k++) edge_sample();
    #2;
    rst_n = 1'b0;
    #1;
    check("midwait_reset_btn_n", 32'(btn_n), 32'hf);
    ticks(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      edge_sample();
      check($sformatf("rerun_btn3_e%0d", k), 32'(btn_n[3]), (k >= 8) ? 32'd0 : 32'd1);
      check($sformatf("rerun_press3_e%0d", k), 32'(press_pulse[3]), (k == 8) ? 32'd1 : 32'd0);
    end
    tick();
    btn_raw_n[3] = 1'b1;
    ticks(12);

    // hl and hr held alternately
    p0 = n_press[0]; p1 = n_press[1]; r0 = n_rel[0]; r1 = n_rel[1];
    for (int r = 0; r < 3; r++) begin
      btn_raw_n[1:0] = 2'b10;
      ticks(20);
      btn_raw_n[1:0] = 2'b01;
      ticks(20);
    end
    btn_raw_n[1:0] = 2'b11;
    ticks(12);
    check("alt_press0", 32'(n_press[0] - p0), 32'd3);
    check("alt_press1", 32'(n_press[1] - p1), 32'd3);
    check("alt_rel0", 32'(n_rel[0] - r0), 32'd3);
    check("alt_rel1", 32'(n_rel[1] - r1), 32'd3);

    // Random bouncing with occasional reset pulses
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 6) == 0) btn_raw_n[i] = ~btn_raw_n[i];
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    btn_raw_n = '1;
    ticks(12);
    check("final_btn_n", 32'(btn_n), 32'hf);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 'd250000: consecutive cycles a synchronized level must hold before it is accepted; legal range 2 to 2^20-1.
REQ-002 The block SHALL have parameter NUM_BUTTONS, default 4: number of independent button channels, ordered hl, hr, vu, vd.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single system clock; all state changes on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide: reset, asynchronous assert, active-low.
REQ-005 Port btn_raw_n SHALL be an input, NUM_BUTTONS bits wide: raw board pushbuttons, asynchronous to clk, 0 = pressed.
REQ-006 Port btn_n SHALL be an output, NUM_BUTTONS bits wide: debounced level, 0 = pressed; drives the hl_button/hr_button inputs of the player controllers directly.
REQ-007 Port press_pulse SHALL be an output, NUM_BUTTONS bits wide: one-cycle high pulse per accepted press.
REQ-008 Port release_pulse SHALL be an output, NUM_BUTTONS bits wide: one-cycle high pulse per accepted release.

Function
REQ-009 Each channel SHALL pass btn_raw_n[i] through a two-flop synchronizer (s1, s2) before any other use; both flops reset to 1.
REQ-010 Each channel SHALL implement a four-state FSM: UP_STABLE, DOWN_WAIT, DOWN_STABLE, UP_WAIT; reset state UP_STABLE.
REQ-011 UP_STABLE SHALL go to DOWN_WAIT with cnt <= 1 when s2 = 0; otherwise it SHALL hold with cnt = 0.
REQ-012 DOWN_WAIT SHALL return to UP_STABLE with cnt <= 0 when s2 = 1; otherwise it SHALL increment cnt, or, if cnt = DEBOUNCE_CYCLES-1, go to DOWN_STABLE with cnt <= 0.
REQ-013 DOWN_STABLE and UP_WAIT SHALL mirror REQ-011 and REQ-012 with the polarity of s2 inverted.
REQ-014 btn_n[i] SHALL be registered: 0 in DOWN_STABLE and UP_WAIT, 1 in UP_STABLE and DOWN_WAIT.
REQ-015 press_pulse[i] SHALL be high for exactly the one cycle following the DOWN_WAIT to DOWN_STABLE transition; release_pulse[i] likewise for UP_WAIT to UP_STABLE.
REQ-016 Latency: with raw held constant, btn_n[i] SHALL change on rising edge DEBOUNCE_CYCLES+1, counted from edge 0 = the first edge that samples the new raw level into s1; the matching pulse SHALL be high during the cycle after that edge.
REQ-017 Any raw excursion seen by s2 for fewer than DEBOUNCE_CYCLES consecutive cycles SHALL produce no change on btn_n and no pulse.
REQ-018 cnt SHALL be 20 bits wide per channel, SHALL never exceed DEBOUNCE_CYCLES-1, and SHALL never wrap.
REQ-019 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each follow REQ-011 to REQ-017 with no priority or interaction.
REQ-020 press_pulse[i] and release_pulse[i] SHALL never be high in the same cycle, and the two pulses on one channel SHALL alternate, press first after reset.

Reset
REQ-021 While rst_n = 0, regardless of clk: s1 = s2 = all ones, FSMs = UP_STABLE, cnt = 0, btn_n = all ones, press_pulse = release_pulse = 0.
REQ-022 Reset asserted mid-wait or mid-press SHALL discard all progress; a button held through deassertion SHALL be re-debounced from cnt = 0 and SHALL produce a press_pulse.
REQ-023 Deassertion of rst_n SHALL be synchronized to clk by two flops internally, so that all channels leave reset on the same edge.

Verification (DEBOUNCE_CYCLES = 4)
REQ-024 The bench SHALL check that btn_raw_n[0] driven to 0 and held gives btn_n[0] = 0 at edge 5 after first sample and press_pulse[0] = 1 for exactly one cycle.
REQ-025 The bench SHALL check that a raw glitch of 3 cycles low on btn_raw_n[1] gives btn_n[1] = 1 throughout and no pulses.
REQ-026 The bench SHALL check that a bouncing release (1,0,1,0 then steady 1) on a pressed channel gives btn_n = 1 only 5 edges after the last transition to 1, with one release_pulse.
REQ-027 The bench SHALL check that pressing all 4 buttons on the same edge makes all of btn_n fall on the same edge with 4 simultaneous press_pulse bits.
REQ-028 The bench SHALL check that rst_n pulsed low while cnt = 2 gives btn_n = 4'b1111 immediately, and that with the button still held, a fresh press is accepted 5 edges after the internally synchronized reset release.
REQ-029 The bench SHALL check that hl and hr held alternately for 20 cycles each give btn_n[0] and btn_n[1] toggling independently, with pulses alternating per channel.
